rec2: RTL

REC2 -- requirements
Module: rec2

---
 rtl/rec2_if.sv | 31 +++
 rtl/rec2.sv | 84 ++++++++
 2 files changed

// File: rtl/rec2_if.sv
// Request/status bundle between the MAC receive logic and the receive error counter.
// The master drives the three requests; the slave (rec2) returns the count and fault flags.
interface rec2_if;
  logic       increc;
  logic       incegrec;
  logic       decrec;
  logic       rec_lt96;
  logic       rec_ge96;
  logic       rec_ge128;
  logic [7:0] reccount;

  modport master (
    output increc,
    output incegrec,
    output decrec,
    input  rec_lt96,
    input  rec_ge96,
    input  rec_ge128,
    input  reccount
  );

  modport slave (
    input  increc,
    input  incegrec,
    input  decrec,
    output rec_lt96,
    output rec_ge96,
    output rec_ge128,
    output reccount
  );
endinterface

// File: rtl/rec2.sv
// Receive error counter with edge-latched requests and fault-state threshold flags.
// Define REC_FLAG_REG_EN to register the flags from the next count instead of decoding the count register.
module rec2 (
  input logic   clock,
  input logic   reset,
  rec2_if.slave bus
);

  localparam int unsigned N_GE = 2;
  localparam logic [7:0] GE_THR [N_GE] = '{8'd96, 8'd128};

  logic [7:0]      cnt_reg;
  logic [7:0]      cnt_next;
  logic            edge_reg;
  logic            action;
  logic            update;
  logic [8:0]      sum8;
  logic [8:0]      sum1;
  logic [N_GE-1:0] ge_flag;

  assign action = bus.increc | bus.incegrec | bus.decrec;
  // Only the first cycle of an action counts; the latch holds until all requests drop.
  assign update = action & ~edge_reg;

  assign sum8 = {1'b0, cnt_reg} + 9'd8;
  assign sum1 = {1'b0, cnt_reg} + 9'd1;

  always_comb begin
    cnt_next = cnt_reg;
    if (update) begin
      if (bus.incegrec) begin
        cnt_next = sum8[8] ? 8'hFF : sum8[7:0];
      end else if (bus.increc) begin
        cnt_next = sum1[8] ? 8'hFF : sum1[7:0];
      end else if (bus.decrec) begin
        // Leaving error passive drops straight back to 120.
        if (cnt_reg[7]) begin
          cnt_next = 8'd120;
        end else if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg  <= 8'd0;
      edge_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      edge_reg <= action;
    end
  end

  genvar gi;
`ifdef REC_FLAG_REG_EN
  generate
    for (gi = 0; gi < N_GE; gi++) begin : g_flag
      logic flag_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          flag_reg <= 1'b0;
        end else begin
          flag_reg <= (cnt_next >= GE_THR[gi]);
        end
      end
      assign ge_flag[gi] = flag_reg;
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < N_GE; gi++) begin : g_flag
      assign ge_flag[gi] = (cnt_reg >= GE_THR[gi]);
    end
  endgenerate
`endif

  assign bus.rec_lt96  = ~ge_flag[0];
  assign bus.rec_ge96  = ge_flag[0];
  assign bus.rec_ge128 = ge_flag[1];
  assign bus.reccount  = cnt_reg;

endmodule
